// File: rtl/reset_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its delay counter.
package reset_pkg;

    typedef enum logic [1:0] {
        RS_ASSERT,
        RS_RELEASE,
        RS_RUN
    } reset_seq_state_t;

    // Width needed to hold the larger of the two phase lengths without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/reset_delay_counter.sv
// Clearable up-counter that stops at a runtime limit and flags terminal count.
module reset_delay_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == limit_i);

    // Holding at the limit keeps the count from ever wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains for a minimum pulse, then releases them one by one in index
// order; a soft request re-runs the sequence and is acknowledged when it completes.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_DOMAINS   = 3,
    parameter int MIN_PULSE     = 8,
    parameter int RELEASE_DELAY = 16
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   soft_rst_req_i,
    output logic                   soft_rst_ack_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
    output logic                   all_released_o,
    output logic                   busy_o
);

    localparam int CNT_W = cnt_width(MIN_PULSE, RELEASE_DELAY);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       PULSE_LIM = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0]       GAP_LIM   = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

    if (NUM_DOMAINS < 1) begin : g_chk_domains
        $error("reset_sequencer: NUM_DOMAINS must be >= 1");
    end
    if (MIN_PULSE < 1) begin : g_chk_pulse
        $error("reset_sequencer: MIN_PULSE must be >= 1");
    end
    if (RELEASE_DELAY < 1) begin : g_chk_delay
        $error("reset_sequencer: RELEASE_DELAY must be >= 1");
    end

    reset_seq_state_t       state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   pend_q, pend_d;
    logic                   ack_q, ack_d;
    logic                   all_rel_q, all_rel_d;
    logic                   busy_q, busy_d;

    logic                   cnt_clr;
    logic                   cnt_en;
    logic                   cnt_tc;
    logic [CNT_W-1:0]       cnt_limit;

    logic                   restart;
    logic                   step;
    logic                   last_step;

    // A request restarts from a full assert in every state; it also wins over a due release.
    assign restart   = soft_rst_req_i;
    assign step      = !restart && (state_q != RS_RUN) && cnt_tc;
    assign last_step = (state_q == RS_ASSERT) ? (NUM_DOMAINS == 1) : (idx_q == LAST_IDX);

    assign cnt_limit = (state_q == RS_ASSERT) ? PULSE_LIM : GAP_LIM;

    reset_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_i),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .tc_o    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RS_ASSERT;
            idx_q     <= '0;
            dom_q     <= '0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dom_q     <= dom_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            all_rel_q <= all_rel_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RS_ASSERT: begin
                if (restart) begin
                    state_d = RS_ASSERT;
                end else if (step) begin
                    state_d = last_step ? RS_RUN : RS_RELEASE;
                end
            end
            RS_RELEASE: begin
                if (restart) begin
                    state_d = RS_ASSERT;
                end else if (step && last_step) begin
                    state_d = RS_RUN;
                end
            end
            RS_RUN: begin
                if (restart) begin
                    state_d = RS_ASSERT;
                end
            end
            default: state_d = RS_ASSERT;
        endcase
    end

    always_comb begin
        dom_d     = dom_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        cnt_en    = (state_q != RS_RUN);
        cnt_clr   = restart || step || (state_q == RS_RUN);
        if (restart) begin
            dom_d  = '0;
            idx_d  = '0;
            pend_d = 1'b1;
        end else if (step) begin
            dom_d = dom_q | (DOM_ONE << idx_q);
            if (last_step) begin
                // The ack marks only the completion of a requested sequence, never power-on.
                ack_d  = pend_q;
                pend_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        all_rel_d = (state_d == RS_RUN);
        busy_d    = (state_d != RS_RUN);
    end

    assign soft_rst_ack_o = ack_q;
    assign domain_rst_n_o = dom_q;
    assign all_released_o = all_rel_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus a minimal 1/1/1 instance,
// both predicted from release-time arithmetic relative to the last sequence start.
module tb_reset_sequencer;

    localparam int NA = 3, MA = 8, RA = 16;
    localparam int NB = 1, MB = 1, RB = 1;
    localparam logic [7:0] RST_VEC = 8'b0100_0000;

    typedef struct {
        int         at;
        logic [7:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst_i;
    logic req;

    logic          ack_a, all_a, busy_a;
    logic [NA-1:0] dom_a;
    logic          ack_b, all_b, busy_b;
    logic [NB-1:0] dom_b;
    logic [7:0]    obs_a, obs_b;

    ev_t        q_a[$];
    ev_t        q_b[$];
    int         checks = 0;
    int         errors = 0;
    int         mon_edge;
    int         e_drv = 0;
    int         seq_start[2];
    bit         pend[2];
    logic [7:0] exp_prev[2];
    logic [7:0] prev_obs[2];

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_DOMAINS(NA), .MIN_PULSE(MA), .RELEASE_DELAY(RA)) dut_a (
        .clk            (clk),
        .rst_i          (rst_i),
        .soft_rst_req_i (req),
        .soft_rst_ack_o (ack_a),
        .domain_rst_n_o (dom_a),
        .all_released_o (all_a),
        .busy_o         (busy_a)
    );

    reset_sequencer #(.NUM_DOMAINS(NB), .MIN_PULSE(MB), .RELEASE_DELAY(RB)) dut_b (
        .clk            (clk),
        .rst_i          (rst_i),
        .soft_rst_req_i (req),
        .soft_rst_ack_o (ack_b),
        .domain_rst_n_o (dom_b),
        .all_released_o (all_b),
        .busy_o         (busy_b)
    );

    assign obs_a = {ack_a, busy_a, all_a, 2'b00, dom_a};
    assign obs_b = {ack_b, busy_b, all_b, 4'b0000, dom_b};

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) mon_edge <= 0;
        else        mon_edge <= mon_edge + 1;
    end

    // Domain k is out of reset from edge s+m+k*r; the sequence is complete at the last one.
    function automatic logic [7:0] model(input int n, input int m, input int r,
                                         input int s, input int e, input bit p);
        logic [4:0] dom;
        int         done;
        dom  = '0;
        done = s + m + (n - 1) * r;
        for (int k = 0; k < n; k++) begin
            if (e >= s + m + k * r) dom[k] = 1'b1;
        end
        return {p && (e == done), e < done, e >= done, dom};
    endfunction

    task automatic step(input bit r);
        ev_t ev;
        int  n, m, rr;
        req = r;
        e_drv++;
        for (int d = 0; d < 2; d++) begin
            n  = (d == 0) ? NA : NB;
            m  = (d == 0) ? MA : MB;
            rr = (d == 0) ? RA : RB;
            if (r) begin
                seq_start[d] = e_drv;
                pend[d]      = 1'b1;
                ev.v         = RST_VEC;
            end else begin
                ev.v = model(n, m, rr, seq_start[d], e_drv, pend[d]);
                if (ev.v[7]) pend[d] = 1'b0;
            end
            ev.at = e_drv;
            if (ev.v !== exp_prev[d]) begin
                exp_prev[d] = ev.v;
                if (d == 0) q_a.push_back(ev);
                else        q_b.push_back(ev);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        req   = 1'b0;
        #1;
        checks++;
        if (obs_a !== RST_VEC) begin
            errors++;
            $display("FAIL dutA reset_state: got %b, required %b", obs_a, RST_VEC);
        end
        checks++;
        if (obs_b !== RST_VEC) begin
            errors++;
            $display("FAIL dutB reset_state: got %b, required %b", obs_b, RST_VEC);
        end
        q_a.delete();
        q_b.delete();
        for (int d = 0; d < 2; d++) begin
            seq_start[d] = 0;
            pend[d]      = 1'b0;
            exp_prev[d]  = RST_VEC;
        end
        e_drv = 0;
        @(negedge clk);
        #1 rst_i = 1'b1;
    endtask

    task automatic run_until(input int last, input int lo, input int hi);
        while (e_drv < last) step((e_drv + 1 >= lo) && (e_drv + 1 <= hi));
    endtask

    task automatic mon(input int d, input logic [7:0] obs);
        ev_t   fr;
        bit    have;
        string nm;
        nm   = (d == 0) ? "dutA" : "dutB";
        have = 1'b0;
        if (d == 0 && q_a.size() > 0) begin have = 1'b1; fr = q_a[0]; end
        if (d == 1 && q_b.size() > 0) begin have = 1'b1; fr = q_b[0]; end
        if (obs !== prev_obs[d]) begin
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL %s unexpected_change: got %b at edge %0d, required %b", nm, obs, mon_edge, prev_obs[d]);
            end else begin
                if (d == 0) void'(q_a.pop_front());
                else        void'(q_b.pop_front());
                if (fr.at != mon_edge || fr.v !== obs) begin
                    errors++;
                    $display("FAIL %s event: got %b at edge %0d, required %b at edge %0d", nm, obs, mon_edge, fr.v, fr.at);
                end
            end
            prev_obs[d] = obs;
        end else if (have && fr.at <= mon_edge) begin
            checks++;
            errors++;
            if (d == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
            $display("FAIL %s missing_change: got %b at edge %0d, required %b at edge %0d", nm, obs, mon_edge, fr.v, fr.at);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                prev_obs[0] = RST_VEC;
                prev_obs[1] = RST_VEC;
            end else begin
                mon(0, obs_a);
                mon(1, obs_b);
            end
        end
    end

    initial begin
        int hold;
        int rst_at;
        bit r;
        rst_i = 1'b1;
        req   = 1'b0;
        #3;
        do_reset();

        // Power-on release, then a one-cycle soft request in RUN at edge 100.
        run_until(180, 100, 100);

        // Abort during RELEASE at edge 30.
        #1 do_reset();
        run_until(100, 30, 30);

        // Request held through the power-on assert phase.
        #1 do_reset();
        run_until(80, 3, 12);

        // Asynchronous reset in the middle of a sequence, then a clean restart.
        #1 do_reset();
        run_until(30, 0, -1);
        #1 do_reset();
        run_until(60, 0, -1);

        // Random requests, including held bursts and one mid-run reset.
        hold   = 0;
        rst_at = $urandom_range(500, 2500);
        for (int i = 0; i < 3000; i++) begin
            if (hold > 0) begin
                r = 1'b1;
                hold--;
            end else if ($urandom_range(0, 49) == 0) begin
                r    = 1'b1;
                hold = $urandom_range(0, 4);
            end else begin
                r = 1'b0;
            end
            if (i == rst_at) begin
                #1 do_reset();
            end
            step(r);
        end
        for (int i = 0; i < 80; i++) step(1'b0);
        @(negedge clk);
        #1;

        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL dutA drain: got %0d pending events, required 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL dutB drain: got %0d pending events, required 0", q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
